// File: rtl/mul_sweep_pkg.sv
// mul_sweep_pkg
//   Shared types and width helpers for the multiplier error-sweep engine.
//   sweep_state_e : engine FSM states.
//   ACC_W(b)      : sum_abs_err width   (4*b)
//   CNT_W(b)      : err_count width     (2*b+1)
//   SQ_W(b)       : sum_sq_err width    (6*b), only used when SWEEP_MSE_EN is defined
package mul_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_e;

    // Widths scale with the operand width of the multiplier under test.
    function automatic int ACC_W(input int b);
        return 4 * b;
    endfunction

    function automatic int CNT_W(input int b);
        return 2 * b + 1;
    endfunction

    function automatic int SQ_W(input int b);
        return 6 * b;
    endfunction

endpackage

// File: rtl/mul_err_sweep_engine_fifo.sv
// sweep_op_fifo
//   Operand queue holding issued {x,y} pairs until their results return.
//   clk, rst  : clock, synchronous active-high reset (empties the queue)
//   push      : write wr_data (dropped when full unless a pop happens too)
//   pop       : drop the head entry (ignored when empty)
//   rd_data   : head entry, valid while count != 0
//   count     : number of stored entries, 0..DEPTH
module sweep_op_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/mul_err_sweep_engine.sv
// mul_err_sweep_engine
//   Sweeps every operand pair (x outer, y inner) through an external multiplier,
//   compares each returned product with the exact one and accumulates error stats.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begins a sweep from IDLE or DONE
//   op_x, op_y, op_valid/op_ready : operand issue handshake
//   res_z, res_valid    : in-order results, no backpressure
//   busy, done          : RUN/DRAIN and DONE indicators
//   protocol_err        : sticky, set by a result with nothing outstanding
//   sum_abs_err, max_abs_err, err_count : error statistics
//   sum_sq_err          : sum of squared errors, present only with SWEEP_MSE_EN
// Build option: define SWEEP_MSE_EN to add the squared-error accumulator.
module mul_err_sweep_engine
    import mul_sweep_pkg::*;
#(
    parameter int BIT   = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [BIT-1:0]          op_x,
    output logic [BIT-1:0]          op_y,
    output logic                    op_valid,
    input  logic                    op_ready,
    input  logic [2*BIT-1:0]        res_z,
    input  logic                    res_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    protocol_err,
    output logic [ACC_W(BIT)-1:0]   sum_abs_err,
    output logic [2*BIT-1:0]        max_abs_err,
    output logic [CNT_W(BIT)-1:0]   err_count
`ifdef SWEEP_MSE_EN
    ,
    output logic [SQ_W(BIT)-1:0]    sum_sq_err
`endif
);
    localparam int PW  = 2 * BIT;
    localparam int AW  = ACC_W(BIT);
    localparam int CW  = CNT_W(BIT);
    localparam int FCW = $clog2(DEPTH) + 1;

    sweep_state_e     state_q, state_d;
    logic [PW-1:0]    idx_q, idx_d;       // {x, y} of the next pair to issue
    logic [AW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    max_q, max_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             perr_q, perr_d;
`ifdef SWEEP_MSE_EN
    localparam int SW = SQ_W(BIT);
    logic [SW-1:0]    sq_q, sq_d;
`endif

    logic [FCW-1:0]   out_cnt;
    logic [PW-1:0]    head;
    logic             issue, accept, clr;
    logic [PW-1:0]    exact, abs_err;
    logic signed [PW:0] diff;

    assign op_valid = (state_q == S_RUN) && (out_cnt < FCW'(DEPTH));
    assign issue    = op_valid && op_ready;
    assign accept   = res_valid && (out_cnt != '0);
    assign clr      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    sweep_op_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue),
        .pop     (accept),
        .wr_data (idx_q),
        .rd_data (head),
        .count   (out_cnt)
    );

    // One extra bit keeps the difference signed; its magnitude fits in PW bits.
    always_comb begin
        exact   = PW'(head[PW-1:BIT]) * PW'(head[BIT-1:0]);
        diff    = $signed({1'b0, res_z}) - $signed({1'b0, exact});
        abs_err = diff[PW] ? PW'(-diff) : diff[PW-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
`ifdef SWEEP_MSE_EN
        sq_d    = sq_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: if (issue) begin
                idx_d = idx_q + PW'(1);
                if (idx_q == '1) state_d = S_DRAIN;
            end
            S_DRAIN: if (out_cnt == '0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (clr) begin
            idx_d  = '0;
            sum_d  = '0;
            max_d  = '0;
            cnt_d  = '0;
            perr_d = 1'b0;
`ifdef SWEEP_MSE_EN
            sq_d   = '0;
`endif
        end else begin
            if (accept) begin
                sum_d = sum_q + AW'(abs_err);
                if (abs_err > max_q) max_d = abs_err;
                if (abs_err != '0)   cnt_d = cnt_q + CW'(1);
`ifdef SWEEP_MSE_EN
                sq_d  = sq_q + SW'(abs_err) * SW'(abs_err);
`endif
            end
            if (res_valid && (out_cnt == '0)) perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
`ifdef SWEEP_MSE_EN
            sq_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
`ifdef SWEEP_MSE_EN
            sq_q    <= sq_d;
`endif
        end
    end

    assign op_x         = idx_q[PW-1:BIT];
    assign op_y         = idx_q[BIT-1:0];
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign protocol_err = perr_q;
    assign sum_abs_err  = sum_q;
    assign max_abs_err  = max_q;
    assign err_count    = cnt_q;
`ifdef SWEEP_MSE_EN
    assign sum_sq_err   = sq_q;
`endif

endmodule

// File: tb/tb_mul_err_sweep_engine.sv
// tb_mul_err_sweep_engine
//   Drives a 4-bit engine (256 pairs per sweep, DEPTH=4) against a modelled
//   multiplier with selectable transfer function, latency and ready pattern.
module tb_mul_err_sweep_engine;
    localparam int BIT   = 4;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * BIT;
    localparam int AW    = 4 * BIT;
    localparam int CW    = 2 * BIT + 1;
    localparam int NP    = 1 << PW;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0;
    logic op_ready = 1'b0, res_valid = 1'b0;
    logic [PW-1:0]  res_z = '0;
    logic [BIT-1:0] op_x, op_y;
    logic op_valid, busy, done, protocol_err;
    logic [AW-1:0]  sum_abs_err;
    logic [PW-1:0]  max_abs_err;
    logic [CW-1:0]  err_count;
`ifdef SWEEP_MSE_EN
    logic [6*BIT-1:0] sum_sq_err;
`endif

    always #5 clk = ~clk;

    mul_err_sweep_engine #(.BIT(BIT), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_x         (op_x),
        .op_y         (op_y),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .res_z        (res_z),
        .res_valid    (res_valid),
        .busy         (busy),
        .done         (done),
        .protocol_err (protocol_err),
        .sum_abs_err  (sum_abs_err),
        .max_abs_err  (max_abs_err),
        .err_count    (err_count)
`ifdef SWEEP_MSE_EN
        ,
        .sum_sq_err   (sum_sq_err)
`endif
    );

    int tests = 0, fails = 0;

    // stimulus knobs, written by the main sequence only
    int z_mode = 0;    // 0: exact, 1: x*y+1, 2: always 0
    int lat = 1;
    bit rdy_tog = 1'b0;
    bit inj = 1'b0;
    bit chk_en = 1'b0;

    // model: outstanding pairs with the cycle their result is due
    typedef struct { int x; int y; int z; int due; } pend_t;
    pend_t pend[$];
    pend_t p;
    longint m_sum = 0, m_sq = 0, e;
    int m_max = 0, m_cnt = 0, m_idx = 0, m_issued = 0, cyc = 0, zv;
    int phase = 0;    // 0 idle, 1 sweeping, 2 finished
    bit m_perr = 1'b0;
    bit prev_stall = 1'b0;
    logic [BIT-1:0] px, py;
    bit exp_busy, exp_done, exp_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle checker and multiplier model. Runs on the falling edge: first
    // compares what the DUT shows, then decides this cycle's inputs and updates
    // the model with what the DUT will absorb on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        exp_busy = (phase == 1);
        exp_done = (phase == 2);
        exp_ov   = (phase == 1) && (m_issued < NP) && (pend.size() < DEPTH);
        if (chk_en && fails < 40) begin
            tests++;
            if (sum_abs_err !== AW'(m_sum) || max_abs_err !== PW'(m_max) ||
                err_count !== CW'(m_cnt) || protocol_err !== m_perr ||
                busy !== exp_busy || done !== exp_done || op_valid !== exp_ov) begin
                fails++;
                $display("FAIL cycle %0d: sum=%0d/%0d max=%0d/%0d cnt=%0d/%0d perr=%0b/%0b busy=%0b/%0b done=%0b/%0b op_valid=%0b/%0b (got/expected)",
                         cyc, sum_abs_err, m_sum, max_abs_err, m_max, err_count, m_cnt,
                         protocol_err, m_perr, busy, exp_busy, done, exp_done, op_valid, exp_ov);
            end
`ifdef SWEEP_MSE_EN
            chk("sum_sq_cycle", 64'(sum_sq_err), 64'(m_sq));
`endif
            if (prev_stall) begin
                tests++;
                if (op_valid !== 1'b1 || op_x !== px || op_y !== py) begin
                    fails++;
                    $display("FAIL stall_hold cycle %0d: op_valid=%0b x=%0d y=%0d, expected 1 x=%0d y=%0d",
                             cyc, op_valid, op_x, op_y, px, py);
                end
            end
        end
        if (phase == 1 && m_issued == NP && pend.size() == 0) phase = 2;

        op_ready  = rdy_tog ? ~op_ready : 1'b1;
        res_valid = 1'b0;
        prev_stall = 1'b0;
        if (rst) begin
            pend.delete();
            m_sum = 0; m_sq = 0; m_max = 0; m_cnt = 0; m_perr = 1'b0;
            m_idx = 0; m_issued = 0; phase = 0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                res_valid = 1'b1;
                res_z = PW'(p.z);
                e = longint'(p.z) - longint'(p.x * p.y);
                if (e < 0) e = -e;
                m_sum += e;
                m_sq  += e * e;
                if (e > m_max) m_max = int'(e);
                if (e != 0) m_cnt++;
            end else if (inj) begin
                res_valid = 1'b1;
                res_z = PW'($urandom);
                if (pend.size() == 0) m_perr = 1'b1;
            end
            if (start && phase != 1) begin
                m_sum = 0; m_sq = 0; m_max = 0; m_cnt = 0; m_perr = 1'b0;
                m_idx = 0; m_issued = 0; phase = 1;
            end
            if (op_valid === 1'b1 && op_ready) begin
                tests++;
                if ({op_x, op_y} !== PW'(m_idx)) begin
                    fails++;
                    $display("FAIL issue_order cycle %0d: got x=%0d y=%0d, expected index %0d",
                             cyc, op_x, op_y, m_idx);
                end
                case (z_mode)
                    0:       zv = int'(op_x) * int'(op_y);
                    1:       zv = int'(op_x) * int'(op_y) + 1;
                    default: zv = 0;
                endcase
                pend.push_back('{int'(op_x), int'(op_y), zv, cyc + lat});
                m_idx++;
                m_issued++;
            end else if (op_valid === 1'b1) begin
                prev_stall = 1'b1;
                px = op_x;
                py = op_y;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic pulse_inj();
        @(posedge clk); #2 inj = 1'b1;
        @(posedge clk); #2 inj = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(posedge clk); #2;
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic wait_issued(input int target);
        int n = 0;
        while (m_issued < target && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("issue_progress", 64'(m_issued >= target), 64'd1);
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_op"}, 64'({op_valid, op_x, op_y}), 64'd0);
        chk({tag, "_stats"}, 64'({protocol_err, sum_abs_err, max_abs_err, err_count}), 64'd0);
`ifdef SWEEP_MSE_EN
        chk({tag, "_sq"}, 64'(sum_sq_err), 64'd0);
`endif
    endtask

    task automatic run_sweep(input string tag, input int zm, input int l, input bit tog,
                             input int e_sum, input int e_max, input int e_cnt, input int e_sq);
        z_mode = zm; lat = l; rdy_tog = tog;
        pulse_start();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_perr_clr"}, 64'(protocol_err), 64'd0);
        wait_done(tag);
        chk({tag, "_sum"}, 64'(sum_abs_err), 64'(e_sum));
        chk({tag, "_max"}, 64'(max_abs_err), 64'(e_max));
        chk({tag, "_cnt"}, 64'(err_count), 64'(e_cnt));
        chk({tag, "_perr"}, 64'(protocol_err), 64'd0);
`ifdef SWEEP_MSE_EN
        chk({tag, "_sq"}, 64'(sum_sq_err), 64'(e_sq));
`else
        if (e_sq < 0) $display("negative square expectation for %s", tag);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        check_zero_state("reset");

        // stray result in IDLE
        pulse_inj();
        chk("idle_inj_perr", 64'(protocol_err), 64'd1);
        chk("idle_inj_stats", 64'({sum_abs_err, max_abs_err, err_count}), 64'd0);

        // 4-bit sweeps: x*y+1 -> 256 unit errors; z=0 -> (0+..+15)^2 = 14400,
        // max 15*15 = 225, 225 nonzero products, squares (sum x^2)^2 = 1240^2
        run_sweep("exact_l1",  0, 1, 1'b0, 0,     0,   0,   0);
        run_sweep("plus1_l3",  1, 3, 1'b0, 256,   1,   256, 256);
        run_sweep("zero_l2_t", 2, 2, 1'b1, 14400, 225, 225, 1537600);

        // stray result in DONE leaves the totals alone
        pulse_inj();
        chk("done_inj_perr", 64'(protocol_err), 64'd1);
        chk("done_inj_sum", 64'(sum_abs_err), 64'd14400);
        chk("done_inj_done", 64'(done), 64'd1);

        run_sweep("exact_l6_t", 0, 6, 1'b1, 0,   0, 0,   0);
        run_sweep("plus1_l6",   1, 6, 1'b0, 256, 1, 256, 256);

        // reset mid-sweep, then a clean sweep with an ignored start in RUN
        z_mode = 1; lat = 1; rdy_tog = 1'b0;
        pulse_start();
        wait_issued(100);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        check_zero_state("midrst");
        pulse_start();
        wait_issued(50);
        pulse_start();
        chk("restart_ignored_busy", 64'(busy), 64'd1);
        wait_done("after_rst");
        chk("after_rst_sum", 64'(sum_abs_err), 64'd256);
        chk("after_rst_max", 64'(max_abs_err), 64'd1);
        chk("after_rst_cnt", 64'(err_count), 64'd256);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
